// File: rtl/mult_uint8_top.sv
// Exact unsigned BIT_WIDTH x BIT_WIDTH multiplier: AND-array partial products, carry-save rows, ripple CPA.
// Latency 1 cycle (registered product), throughput 1/cycle, no backpressure; async active-high reset clears out.
module mult_uint8_top #(
    parameter int BIT_WIDTH = 8,
    parameter int OUT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    output logic [OUT_WIDTH-1:0] out
);

    if (OUT_WIDTH != 2 * BIT_WIDTH) begin : g_width_check
        $error("mult_uint8_top: OUT_WIDTH must equal 2*BIT_WIDTH");
    end

    // Partial-product rows, each already shifted to its weight.
    logic [OUT_WIDTH-1:0] pp_row [BIT_WIDTH];

    for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_pp
        for (genvar k = 0; k < OUT_WIDTH; k++) begin : g_bit
            if (k >= i && k < i + BIT_WIDTH) begin : g_and
                assign pp_row[i][k] = in_a[k-i] & in_b[i];
            end else begin : g_zero
                assign pp_row[i][k] = 1'b0;
            end
        end
    end

    // Carry-save accumulation: one full-adder row per partial product keeps
    // the running total as (sum_row + carry_row). Carries shifted out of the
    // top are always zero because the exact product fits in OUT_WIDTH bits.
    logic [OUT_WIDTH-1:0] sum_row   [BIT_WIDTH];
    logic [OUT_WIDTH-1:0] carry_row [BIT_WIDTH];

    assign sum_row[0]   = pp_row[0];
    assign carry_row[0] = '0;

    for (genvar i = 1; i < BIT_WIDTH; i++) begin : g_csa
        logic [OUT_WIDTH-1:0] maj;
        assign sum_row[i]   = sum_row[i-1] ^ carry_row[i-1] ^ pp_row[i];
        assign maj          = (sum_row[i-1] & carry_row[i-1])
                            | (sum_row[i-1] & pp_row[i])
                            | (carry_row[i-1] & pp_row[i]);
        assign carry_row[i] = {maj[OUT_WIDTH-2:0], 1'b0};
    end

    logic [OUT_WIDTH-1:0] cpa_sum;

    always_comb begin
        logic c;
        logic x;
        logic y;
        cpa_sum = '0;
        c       = 1'b0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            x          = sum_row[BIT_WIDTH-1][k];
            y          = carry_row[BIT_WIDTH-1][k];
            cpa_sum[k] = x ^ y ^ c;
            c          = (x & y) | (x & c) | (y & c);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= cpa_sum;
        end
    end

endmodule

// File: tb/tb_mult_uint8_top.sv
// Bench for mult_uint8_top: vector table, back-to-back stream, reset corners, exhaustive sweep, random vs model.
module tb_mult_uint8_top;

    logic        clk;
    logic        rst;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic [15:0] out;

    int n_cmp;
    int n_bad;

    typedef struct {
        string       name;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    mult_uint8_top #(.BIT_WIDTH(8), .OUT_WIDTH(16)) dut (
        .clk  (clk),
        .rst  (rst),
        .in_a (in_a),
        .in_b (in_b),
        .out  (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    // Drive operands away from the edge, then look at out just after the edge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        in_a = a;
        in_b = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{"zero_x_ff",  8'h00, 8'hFF, 16'h0000};
        vecs[1] = '{"one_x_ab",   8'h01, 8'hAB, 16'h00AB};
        vecs[2] = '{"ff_x_ff",    8'hFF, 8'hFF, 16'hFE01};
        vecs[3] = '{"80_x_02",    8'h80, 8'h02, 16'h0100};
        vecs[4] = '{"0f_x_0f",    8'h0F, 8'h0F, 16'h00E1};
        vecs[5] = '{"f0_x_10",    8'hF0, 8'h10, 16'h0F00};
        vecs[6] = '{"55_x_aa",    8'h55, 8'hAA, 16'h3872};
        vecs[7] = '{"ab_x_01",    8'hAB, 8'h01, 16'h00AB};

        rst  = 1'b1;
        in_a = 8'h00;
        in_b = 8'h00;
        #1;
        check("reset_state", out, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_held", out, 16'h0000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply(vecs[i].a, vecs[i].b);
            check(vecs[i].name, out, vecs[i].exp);
        end

        // Consecutive edges with operands changing every cycle.
        apply(8'h0F, 8'h0F);
        check("b2b_0", out, 16'h00E1);
        apply(8'hF0, 8'h10);
        check("b2b_1", out, 16'h0F00);
        apply(8'h55, 8'hAA);
        check("b2b_2", out, 16'h3872);

        // Async reset with nonzero out: cleared before any clock edge.
        apply(8'hFF, 8'hFF);
        check("pre_reset_ff", out, 16'hFE01);
        #2;
        rst = 1'b1;
        #1;
        check("async_clear", out, 16'h0000);
        @(posedge clk);
        #1;
        check("reset_hold_edge", out, 16'h0000);
        @(negedge clk);
        rst  = 1'b0;
        in_a = 8'h12;
        in_b = 8'h34;
        @(posedge clk);
        #1;
        check("first_after_release", out, 16'h03A8);

        // Half-cycle reset pulse between vectors.
        #1;
        rst = 1'b1;
        #1;
        check("pulse_zero", out, 16'h0000);
        @(negedge clk);
        rst  = 1'b0;
        in_a = 8'hC3;
        in_b = 8'h7E;
        @(posedge clk);
        #1;
        check("pulse_release", out, model(8'hC3, 8'h7E));

        // Unknown operands for one cycle, then a valid pair must be exact.
        @(negedge clk);
        in_a = 8'hxx;
        in_b = 8'h5A;
        @(posedge clk);
        apply(8'h9D, 8'h3C);
        check("after_x", out, 16'h24CC);

        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                apply(a[7:0], b[7:0]);
                check("sweep", out, model(a[7:0], b[7:0]));
            end
        end

        for (int i = 0; i < 2000; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            apply(ra, rb);
            check("random", out, model(ra, rb));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
